// File: rtl/oc4_bridge_pkg.sv
// oc4_bridge_pkg: per-VC payload layouts, default depths, pack/unpack helpers and bridge FSM states
package oc4_bridge_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_LOAD, ST_RUN} bridge_state_e;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] afutag;
    logic [1:0]  dl;
    logic [1:0]  dp;
    logic [3:0]  resp_code;
    logic [23:0] host_tag;
  } vc0_t;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] capptag;
    logic [63:0] pa;
    logic [1:0]  dl;
    logic [2:0]  pl;
    logic [63:0] be;
    logic        t;
    logic [3:0]  flag;
    logic        os;
    logic [4:0]  mad;
  } vc1_t;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [11:0] actag;
    logic [3:0]  stream_id;
    logic [63:0] ea;
    logic [15:0] afutag;
    logic [1:0]  dl;
    logic [2:0]  pl;
    logic        os;
    logic [15:0] bdf;
    logic [19:0] pasid;
    logic [3:0]  flag;
    logic [7:0]  cmd_mad;
  } vc3_t;
  localparam int VC0_PAYLOAD_W = $bits(vc0_t);
  localparam int VC1_PAYLOAD_W = $bits(vc1_t);
  localparam int VC3_PAYLOAD_W = $bits(vc3_t);
  localparam int VC0_OPCODE_LSB = 48;
  localparam int VC0_AFUTAG_LSB = 32;
  localparam int VC1_OPCODE_LSB = 160;
  localparam int VC1_CAPPTAG_LSB = 144;
  localparam int VC1_PA_LSB = 80;
  localparam int VC3_OPCODE_LSB = 150;
  localparam int VC3_EA_LSB = 70;
  localparam int VC3_AFUTAG_LSB = 54;
  localparam int VC0_FIFO_DEPTH = 8;
  localparam int VC1_FIFO_DEPTH = 8;
  localparam int VC3_FIFO_DEPTH = 16;
  function automatic logic [VC0_PAYLOAD_W-1:0] pack_vc0(vc0_t f);
    return f;
  endfunction
  function automatic vc0_t unpack_vc0(logic [VC0_PAYLOAD_W-1:0] p);
    return vc0_t'(p);
  endfunction
  function automatic logic [VC1_PAYLOAD_W-1:0] pack_vc1(vc1_t f);
    return f;
  endfunction
  function automatic vc1_t unpack_vc1(logic [VC1_PAYLOAD_W-1:0] p);
    return vc1_t'(p);
  endfunction
  function automatic logic [VC3_PAYLOAD_W-1:0] pack_vc3(vc3_t f);
    return f;
  endfunction
  function automatic vc3_t unpack_vc3(logic [VC3_PAYLOAD_W-1:0] p);
    return vc3_t'(p);
  endfunction
endpackage

// File: rtl/oc4_vc_credit_bridge_if.sv
// oc4_vc_credit_bridge_if: one VC channel, TLX side (valid/payload in, credits out) and AFU side (credits in, valid/payload out)
// master: drives tlx_vc_valid, tlx_vc_payload, afu_initial_credit, afu_credit; slave: the bridge
interface oc4_vc_credit_bridge_if
  import oc4_bridge_pkg::*;
#(
  parameter int PAYLOAD_W = VC1_PAYLOAD_W,
  parameter int CREDIT_W = 7
);
  logic                 tlx_vc_valid;
  logic [PAYLOAD_W-1:0] tlx_vc_payload;
  logic [CREDIT_W-1:0]  afu_tlx_vc_initial_credit;
  logic                 afu_tlx_vc_credit;
  logic [CREDIT_W-1:0]  afu_initial_credit;
  logic                 afu_credit;
  logic                 afu_vc_valid;
  logic [PAYLOAD_W-1:0] afu_vc_payload;
  modport master (
    output tlx_vc_valid, tlx_vc_payload, afu_initial_credit, afu_credit,
    input  afu_tlx_vc_initial_credit, afu_tlx_vc_credit, afu_vc_valid, afu_vc_payload
  );
  modport slave (
    input  tlx_vc_valid, tlx_vc_payload, afu_initial_credit, afu_credit,
    output afu_tlx_vc_initial_credit, afu_tlx_vc_credit, afu_vc_valid, afu_vc_payload
  );
endinterface

// File: rtl/oc4_bridge_fifo.sv
// oc4_bridge_fifo: power-of-2 synchronous FIFO with simultaneous push/pop and occupancy level
// ports: clock, reset_n (async active-low), push/pop (pre-qualified), din, head (current head entry), level
module oc4_bridge_fifo #(
  parameter int W = 168,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else begin
      wr    <= wr + AW'(push);
      rd    <= rd + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem[wr] <= din;
  end
  assign head = mem[rd];
endmodule

// File: rtl/oc4_vc_credit_bridge.sv
// oc4_vc_credit_bridge: registered credit-managed bridge from one TLX VC to the matching AFU port
// ports: clock, reset_n (async active-low), bus (slave modport: TLX valid/payload/credits, AFU valid/payload/credits),
//        fifo_level (occupancy), overflow_err (sticky drop), credit_err (sticky excess AFU credit)
module oc4_vc_credit_bridge
  import oc4_bridge_pkg::*;
#(
  parameter int PAYLOAD_W = 168,
  parameter int FIFO_DEPTH = 8,
  parameter int CREDIT_W = 7,
  parameter bit PASSTHRU = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  oc4_vc_credit_bridge_if.slave       bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow_err,
  output logic                        credit_err
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  if (PASSTHRU) begin : g_pass
    assign bus.afu_vc_valid              = bus.tlx_vc_valid;
    assign bus.afu_vc_payload            = bus.tlx_vc_payload;
    assign bus.afu_tlx_vc_initial_credit = bus.afu_initial_credit;
    assign bus.afu_tlx_vc_credit         = bus.afu_credit;
    assign fifo_level                    = '0;
    assign overflow_err                  = 1'b0;
    assign credit_err                    = 1'b0;
  end else begin : g_bridge
    bridge_state_e        state;
    logic [CREDIT_W-1:0]  cnt;
    logic [PAYLOAD_W-1:0] head, stage_d, out_d;
    logic                 stage_v, out_v, ovf, cerr;
    logic                 pop, push_ok, credit_in, credit_bad;
    logic [LW-1:0]        level;
    assign pop       = state == ST_RUN && level != '0 && cnt != '0;
    assign push_ok   = bus.tlx_vc_valid && (level != LW'(FIFO_DEPTH) || pop);
    assign credit_in = bus.afu_credit && state == ST_RUN;
    // a credit racing a pop nets to zero and cannot overrun; a zero initial credit has no ceiling but the counter max
    assign credit_bad = credit_in && !pop &&
                        (cnt == '1 || (bus.afu_initial_credit != '0 && cnt == bus.afu_initial_credit));
    oc4_bridge_fifo #(.W(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock(clock), .reset_n(reset_n), .push(push_ok), .pop(pop),
      .din(bus.tlx_vc_payload), .head(head), .level(level)
    );
    // popped entry passes through one staging register before the AFU-facing output register
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state   <= ST_INIT;
        cnt     <= '0;
        stage_v <= 1'b0;
        stage_d <= '0;
        out_v   <= 1'b0;
        out_d   <= '0;
        ovf     <= 1'b0;
        cerr    <= 1'b0;
      end else begin
        state   <= state == ST_INIT ? ST_LOAD : ST_RUN;
        cnt     <= state == ST_LOAD ? bus.afu_initial_credit :
                   (pop && !credit_in) ? cnt - 1'b1 :
                   (credit_in && !pop && !credit_bad) ? cnt + 1'b1 : cnt;
        stage_v <= pop;
        stage_d <= pop ? head : stage_d;
        out_v   <= stage_v;
        out_d   <= stage_v ? stage_d : out_d;
        ovf     <= ovf | (bus.tlx_vc_valid && !push_ok);
        cerr    <= cerr | credit_bad;
      end
    end
    assign bus.afu_vc_valid              = out_v;
    assign bus.afu_vc_payload            = out_d;
    assign bus.afu_tlx_vc_credit         = out_v;
    assign bus.afu_tlx_vc_initial_credit = CREDIT_W'(FIFO_DEPTH);
    assign fifo_level                    = level;
    assign overflow_err                  = ovf;
    assign credit_err                    = cerr;
  end
endmodule
